inst_fetcher: RTL
=================

Name: inst_fetcher

Overview:
- Instruction-fetch front end; the initiator on the fetch port that memCtrl serves (flag_from_if / mem_req_from_if in, flag_to_if / inst_to_if out).
- Holds the PC and a direct-mapped, one-word-per-line instruction cache.
- On a miss, requests one 32-bit word from memCtrl. On a hit, issues {inst, pc} to the decoder.
- Accepts redirects from commit/branch resolution.

Parameters:
RESET_PC, 32'h0, PC value loaded at reset
ICACHE_LINES, 16, number of cache lines (power of 2, >=2); index = pc[IDX+1:2], tag = pc[31:IDX+2], IDX = log2(ICACHE_LINES)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
rdy  in  1  global enable; 0 freezes all state
flag_to_mc  out  1  fetch request to memCtrl; level, held until answered
addr_to_mc  out  32  word address of request; bits [1:0] = 0
flag_from_mc  in  1  one-cycle pulse: inst_from_mc valid
inst_from_mc  in  32  fetched instruction word
stall_from_dec  in  1  decoder/issue queue full; block issue
flag_to_dec  out  1  one-cycle pulse: instruction valid
inst_to_dec  out  32  issued instruction
pc_to_dec  out  32  PC of issued instruction
flag_jump  in  1  redirect request
jump_pc  in  32  redirect target; bits [1:0] ignored, treated as 0

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC, state=IDLE, all valid bits=0.
  - flag_to_mc=0, addr_to_mc=0, flag_to_dec=0, inst_to_dec=0, pc_to_dec=0.
- rdy=0: no register changes, outputs hold. A flag_from_mc pulse in such a cycle is not observed; memCtrl freezes under the same rdy.
- Every enabled cycle, flag_to_dec defaults to 0 (pulse semantics).
- States:
  - IDLE:
    - flag_jump=1: pc<=jump_pc&~3, no issue, no request this cycle.
    - Else if valid[idx] && tag matches && !stall_from_dec: flag_to_dec<=1, inst_to_dec<=line data, pc_to_dec<=pc, pc<=pc+4 (32-bit wrap, 32'hFFFFFFFC+4 -> 0).
    - Else if miss (regardless of stall): flag_to_mc<=1, addr_to_mc<=pc, state<=WAIT_MEM.
    - Else (hit but stalled): hold.
  - WAIT_MEM:
    - flag_to_mc and addr_to_mc held constant; a request is never withdrawn.
    - flag_from_mc=1: write line[addr_to_mc idx]<=inst_from_mc, set valid and tag from addr_to_mc, flag_to_mc<=0, state<=IDLE.
    - flag_jump=1 in WAIT_MEM: pc<=jump_pc&~3 only. The outstanding request completes and fills normally (its address is genuine), but the word is not issued unless the new pc hits.
    - Jump and response in the same cycle: both take effect.
- Latency:
  - Hit: 1 cycle from pc valid to flag_to_dec.
  - Miss: request asserted the cycle after lookup; the instruction issues 1 cycle after the response pulse, via the hit path.
- Handshake guarantee: flag_to_mc falls on the same edge that samples flag_from_mc=1, and stays low for at least one cycle before the next request. memCtrl never sees back-to-back requests without a gap.
- Only one outstanding request at any time.
- No speculation beyond pc+4; no branch prediction in this block.

Decomposition:
- Shared definition include: ADDR_TYPE, INS_TYPE, TRUE/FALSE, ZERO_WORD, and a new ICACHE_LINES default.
- Natural sub-module: icache_dm. Valid/tag/data arrays with combinational hit/data lookup and a single write port. The FSM and PC stay in inst_fetcher.

Test Plan:
- Reset release with RESET_PC=0, cold cache: flag_to_mc=1, addr_to_mc=0 on the first enabled cycle. Memory answers 32'h00000513 after 5 cycles. One cycle later flag_to_dec=1, inst=32'h00000513, pc_to_dec=0. Next request addr=4.
- Refetch after a jump back to 0 (loop of 3 words, all cached): three consecutive flag_to_dec pulses for pc 0, 4, 8 with no flag_to_mc activity.
- stall_from_dec=1 for 4 cycles while hitting: no flag_to_dec, pc held. Release: issue resumes at the same pc, with no lost or duplicated instruction.
- flag_jump with jump_pc=32'h1003 while WAIT_MEM on addr 8: request held until response. Line 8 filled, nothing issued for 8, next request addr=32'h1000.
- Aliasing with ICACHE_LINES=16: fetch 0x00 then 0x40 (same index). 0x40 misses and evicts 0x00; a jump back to 0 misses again.
- rdy=0 for 3 cycles mid-WAIT_MEM, plus async rst pulse mid-WAIT_MEM:
  - rdy=0: all outputs frozen.
  - rst: immediately flag_to_mc=0, flag_to_dec=0, all valid bits cleared.

Source files
------------

// File: rtl/inst_fetcher_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Word/address types, truth constants and the fetch FSM state encoding.
package inst_fetcher_pkg;

  typedef logic [31:0] ADDR_TYPE;
  typedef logic [31:0] INS_TYPE;

  localparam logic     TRUE             = 1'b1;
  localparam logic     FALSE            = 1'b0;
  localparam ADDR_TYPE ZERO_WORD        = 32'h0;
  localparam int       ICACHE_LINES_DEF = 16;

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_WAIT_MEM = 1'b1
  } fetch_state_e;

  function automatic ADDR_TYPE word_align(input ADDR_TYPE a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetcher_if.sv
// Fetch-side bus: memCtrl request/response, decoder issue, redirect input.
// master = inst_fetcher, slave = the memCtrl/decoder/commit environment.
interface inst_fetcher_if;
  import inst_fetcher_pkg::*;

  logic     flag_to_mc;
  ADDR_TYPE addr_to_mc;
  logic     flag_from_mc;
  INS_TYPE  inst_from_mc;
  logic     stall_from_dec;
  logic     flag_to_dec;
  INS_TYPE  inst_to_dec;
  ADDR_TYPE pc_to_dec;
  logic     flag_jump;
  ADDR_TYPE jump_pc;

  modport master (
    output flag_to_mc, addr_to_mc, flag_to_dec, inst_to_dec, pc_to_dec,
    input  flag_from_mc, inst_from_mc, stall_from_dec, flag_jump, jump_pc
  );

  modport slave (
    input  flag_to_mc, addr_to_mc, flag_to_dec, inst_to_dec, pc_to_dec,
    output flag_from_mc, inst_from_mc, stall_from_dec, flag_jump, jump_pc
  );

endinterface

// File: rtl/inst_fetcher_icache_dm.sv
// Direct-mapped, one-word-per-line instruction cache.
// Combinational hit/data lookup, one write port; only valid bits are reset.
module inst_fetcher_icache_dm
  import inst_fetcher_pkg::*;
#(
  parameter int LINES = ICACHE_LINES_DEF
) (
  input  logic     clk,
  input  logic     rst,
  input  ADDR_TYPE i_rd_addr,
  output logic     o_hit,
  output INS_TYPE  o_rd_data,
  input  logic     i_wr_en,
  input  ADDR_TYPE i_wr_addr,
  input  INS_TYPE  i_wr_data
);

  localparam int IDX  = $clog2(LINES);
  localparam int TAGW = 30 - IDX;

  logic [LINES-1:0] r_valid;
  logic [TAGW-1:0]  r_tag  [LINES];
  INS_TYPE          r_data [LINES];

  logic [IDX-1:0]  w_rd_idx;
  logic [IDX-1:0]  w_wr_idx;
  logic [TAGW-1:0] w_rd_tag;
  logic [TAGW-1:0] w_wr_tag;

  assign w_rd_idx = i_rd_addr[IDX+1:2];
  assign w_rd_tag = i_rd_addr[31:IDX+2];
  assign w_wr_idx = i_wr_addr[IDX+1:2];
  assign w_wr_tag = i_wr_addr[31:IDX+2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[w_wr_idx] <= TRUE;
    end
  end

  // Tag/data need no reset: they are never read while the line is invalid.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[w_wr_idx]  <= w_wr_tag;
      r_data[w_wr_idx] <= i_wr_data;
    end
  end

  assign o_hit     = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
  assign o_rd_data = r_data[w_rd_idx];

endmodule

// File: rtl/inst_fetcher.sv
// Instruction-fetch front end: PC, fetch FSM and memCtrl request handshake.
// state      | meaning
// S_IDLE     | look up pc; issue on hit, raise a request on miss
// S_WAIT_MEM | one request outstanding; wait for the memCtrl response pulse
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter ADDR_TYPE RESET_PC     = 32'h0,
  parameter int       ICACHE_LINES = ICACHE_LINES_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  inst_fetcher_if.master fetch
);

  fetch_state_e r_state, w_nxt_state;
  ADDR_TYPE     r_pc, w_nxt_pc;
  logic         r_flag_to_mc, w_nxt_flag_to_mc;
  ADDR_TYPE     r_addr_to_mc, w_nxt_addr_to_mc;
  logic         r_flag_to_dec, w_nxt_flag_to_dec;
  INS_TYPE      r_inst_to_dec, w_nxt_inst_to_dec;
  ADDR_TYPE     r_pc_to_dec, w_nxt_pc_to_dec;

  logic    w_hit;
  INS_TYPE w_line_data;
  logic    w_fill;

  // The fill address is the registered request address, so a redirect
  // during WAIT_MEM cannot misplace the returning word.
  assign w_fill = rdy && (r_state == S_WAIT_MEM) && fetch.flag_from_mc;

  inst_fetcher_icache_dm #(.LINES(ICACHE_LINES)) u_icache (
    .clk       (clk),
    .rst       (rst),
    .i_rd_addr (r_pc),
    .o_hit     (w_hit),
    .o_rd_data (w_line_data),
    .i_wr_en   (w_fill),
    .i_wr_addr (r_addr_to_mc),
    .i_wr_data (fetch.inst_from_mc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_flag_to_mc  <= FALSE;
      r_addr_to_mc  <= ZERO_WORD;
      r_flag_to_dec <= FALSE;
      r_inst_to_dec <= ZERO_WORD;
      r_pc_to_dec   <= ZERO_WORD;
    end else if (rdy) begin
      r_state       <= w_nxt_state;
      r_pc          <= w_nxt_pc;
      r_flag_to_mc  <= w_nxt_flag_to_mc;
      r_addr_to_mc  <= w_nxt_addr_to_mc;
      r_flag_to_dec <= w_nxt_flag_to_dec;
      r_inst_to_dec <= w_nxt_inst_to_dec;
      r_pc_to_dec   <= w_nxt_pc_to_dec;
    end
  end

  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_pc          = r_pc;
    w_nxt_flag_to_mc  = r_flag_to_mc;
    w_nxt_addr_to_mc  = r_addr_to_mc;
    w_nxt_flag_to_dec = FALSE;
    w_nxt_inst_to_dec = r_inst_to_dec;
    w_nxt_pc_to_dec   = r_pc_to_dec;
    case (r_state)
      S_IDLE: begin
        if (fetch.flag_jump) begin
          w_nxt_pc = word_align(fetch.jump_pc);
        end else if (w_hit && !fetch.stall_from_dec) begin
          w_nxt_flag_to_dec = TRUE;
          w_nxt_inst_to_dec = w_line_data;
          w_nxt_pc_to_dec   = r_pc;
          w_nxt_pc          = r_pc + 32'd4;
        end else if (!w_hit) begin
          w_nxt_flag_to_mc = TRUE;
          w_nxt_addr_to_mc = r_pc;
          w_nxt_state      = S_WAIT_MEM;
        end
      end
      S_WAIT_MEM: begin
        if (fetch.flag_jump) begin
          w_nxt_pc = word_align(fetch.jump_pc);
        end
        if (fetch.flag_from_mc) begin
          w_nxt_flag_to_mc = FALSE;
          w_nxt_state      = S_IDLE;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  assign fetch.flag_to_mc  = r_flag_to_mc;
  assign fetch.addr_to_mc  = r_addr_to_mc;
  assign fetch.flag_to_dec = r_flag_to_dec;
  assign fetch.inst_to_dec = r_inst_to_dec;
  assign fetch.pc_to_dec   = r_pc_to_dec;

endmodule
